// File: rtl/approx_mul_err_monitor.sv
// Error-statistics collector for 8x8 approximate multipliers: accumulates error count,
// error-distance sum/max (and optional signed bias, macro ERR_BIAS_EN) over N_SAMPLES samples.
module approx_mul_err_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      prod_approx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [ACC_W:0]   sum_bias,
  output logic [1:0]       dbg_state
);

  // Handshake: a sample is consumed on any rising edge where in_valid && in_ready;
  // in_valid may drop at will, in_ready never depends on in_valid.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] N_COUNT = 16'(N_SAMPLES);
  localparam logic [15:0] N_LAST  = 16'(N_SAMPLES - 1);

  state_t      state, state_nxt;
  logic        clear;
  logic        accept;
  logic        last_accept;
  logic [15:0] acc_cnt;
  logic        done_r;

  logic        s1_valid;
  logic [15:0] s1_approx;
  logic [15:0] s1_exact;
  logic        s2_valid;
  logic        s2_nz;
  logic [15:0] s2_ed;

  logic [ACC_W:0] sum_ext;

  assign in_ready    = (state == S_RUN) && (acc_cnt < N_COUNT);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == N_LAST);
  assign busy        = (state == S_RUN) || (state == S_DRAIN);
  assign done        = done_r;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      S_RUN: begin
        if (last_accept) state_nxt = S_DRAIN;
      end
      // Stage 2 still holds the last sample when stage 1 empties; it lands on this edge.
      S_DRAIN: begin
        if (!s1_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          clear     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      done_r  <= 1'b0;
      acc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == S_DRAIN) && (state_nxt == S_DONE);
      if (clear)       acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
      s2_valid  <= 1'b0;
      s2_nz     <= 1'b0;
      s2_ed     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_approx <= prod_approx;
        s1_exact  <= 16'(a) * 16'(b);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_nz <= (s1_approx != s1_exact);
        s2_ed <= (s1_approx >= s1_exact) ? (s1_approx - s1_exact) : (s1_exact - s1_approx);
      end
    end
  end

  assign sum_ext = {1'b0, sum_ed} + {{(ACC_W-15){1'b0}}, s2_ed};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (s2_valid) begin
      err_count <= err_count + {15'd0, s2_nz};
      sum_ed    <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (s2_ed > max_ed) max_ed <= s2_ed;
    end
  end

`ifdef ERR_BIAS_EN
  logic [16:0]    s2_diff;
  logic [ACC_W+1:0] bias_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_diff <= '0;
    end else if (s1_valid) begin
      s2_diff <= {1'b0, s1_approx} - {1'b0, s1_exact};
    end
  end

  // One guard bit: overflow shows as disagreement between the two top bits.
  assign bias_ext = {sum_bias[ACC_W], sum_bias} + {{(ACC_W-15){s2_diff[16]}}, s2_diff};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_bias <= '0;
    end else if (s2_valid) begin
      if (bias_ext[ACC_W+1] != bias_ext[ACC_W])
        sum_bias <= bias_ext[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
      else
        sum_bias <= bias_ext[ACC_W:0];
    end
  end
`else
  assign sum_bias = '0;
`endif

endmodule
